// File: rtl/mem_access_unit.sv
// MEM stage: runs one req/ack data-memory transaction per load/store, stalls
// the pipeline while it is pending and drives the MEM/WB register.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemtoReg,
    input  logic        MEM_MemWrite,
    input  logic        MEM_RegWrite,
    input  logic [31:0] MEM_ALU_result,
    input  logic [31:0] MEM_write_data_mem,
    input  logic [4:0]  MEM_write_register,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        WB_RegWrite,
    output logic        WB_MemtoReg,
    output logic [31:0] WB_read_data,
    output logic [31:0] WB_ALU_result,
    output logic [4:0]  WB_write_register
);
    // Keep at least one counter bit so TIMEOUT=0 still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic          reqNext, weNext, faultNext;
    logic [31:0]   addrNext, wdataNext;
    logic          wbRegWriteNext, wbMemtoRegNext;
    logic [31:0]   wbReadDataNext, wbAluNext;
    logic [4:0]    wbWregNext;

    logic access, misaligned, timeoutHit, loadAck;

    assign access     = MEM_MemRead | MEM_MemWrite;
    assign misaligned = access && (MEM_ALU_result[1:0] != 2'b00);
    assign timeoutHit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    assign loadAck    = (state == WAIT) && dmem_ack && !dmem_we;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        reqNext   = dmem_req;
        weNext    = dmem_we;
        addrNext  = dmem_addr;
        wdataNext = dmem_wdata;
        faultNext = 1'b0;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    mem_stall = 1'b1;
                    stateNext = WAIT;
                    reqNext   = 1'b1;
                    weNext    = MEM_MemWrite;
                    addrNext  = MEM_ALU_result;
                    wdataNext = MEM_write_data_mem;
                    cntNext   = '0;
                end else if (misaligned) begin
                    faultNext = 1'b1;
                end
            end
            WAIT: begin
                // An ack in the last allowed cycle still wins over the timeout.
                if (dmem_ack) begin
                    stateNext = IDLE;
                    reqNext   = 1'b0;
                end else if (timeoutHit) begin
                    stateNext = IDLE;
                    reqNext   = 1'b0;
                    faultNext = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                    cntNext   = cnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        wbRegWriteNext = 1'b0;
        wbMemtoRegNext = WB_MemtoReg;
        wbAluNext      = WB_ALU_result;
        wbWregNext     = WB_write_register;
        wbReadDataNext = WB_read_data;
        if (!mem_stall) begin
            wbRegWriteNext = MEM_RegWrite & ~faultNext;
            wbMemtoRegNext = MEM_MemtoReg;
            wbAluNext      = MEM_ALU_result;
            wbWregNext     = MEM_write_register;
            wbReadDataNext = loadAck ? dmem_rdata : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            dmem_addr         <= 32'h0;
            dmem_wdata        <= 32'h0;
            mem_fault         <= 1'b0;
            WB_RegWrite       <= 1'b0;
            WB_MemtoReg       <= 1'b0;
            WB_read_data      <= 32'h0;
            WB_ALU_result     <= 32'h0;
            WB_write_register <= 5'h0;
        end else begin
            state             <= stateNext;
            cnt               <= cntNext;
            dmem_req          <= reqNext;
            dmem_we           <= weNext;
            dmem_addr         <= addrNext;
            dmem_wdata        <= wdataNext;
            mem_fault         <= faultNext;
            WB_RegWrite       <= wbRegWriteNext;
            WB_MemtoReg       <= wbMemtoRegNext;
            WB_read_data      <= wbReadDataNext;
            WB_ALU_result     <= wbAluNext;
            WB_write_register <= wbWregNext;
        end
    end
endmodule
